coffee_dispense_ctrl: RTL and testbench
=======================================

# coffee_dispense_ctrl

Downstream stage of the coffee vending controller. Consumes the one-cycle drink-release strobe (`out_en` with 4-bit selection `out`) and the change strobe (`change_en` with 2-bit coin count `change`), then sequences the physical dispense. The sequence is cup check, brew heater, one-hot pour valve for the selected drink, and timed change-coin ejector pulses. Reports `busy`/`done` status back to the front panel.

## Interface
Parameters:
- `BREW_CYCLES`, default 8: cycles `brew_on` is held (≥1).
- `POUR_CYCLES`, default 4: cycles the pour valve is held (≥1).
- `CUP_WAIT`, default 16: max cycles waiting for `cup_present` (≥1).
- `COIN_PULSE`, default 2: `coin_eject` high time per coin (≥1).
- `COIN_GAP`, default 2: `coin_eject` low time after each coin (≥1).

Ports:
- `clk` in 1: single clock. Rising edge.
- `rst` in 1: synchronous, active-high reset.
- `out_en` in 1: drink-release strobe, 1 cycle.
- `out` in 4: drink selection, button bitmap.
- `change_en` in 1: change strobe, 1 cycle (normally coincident with `out_en`).
- `change` in 2: number of 5-unit coins to return (0–3).
- `cup_present` in 1: cup sensor, level.
- `busy` out 1: high in every state except IDLE.
- `brew_on` out 1: heater/brew enable.
- `pour_on` out 4: one-hot pour valve.
- `coin_eject` out 1: change ejector solenoid.
- `done` out 1: 1-cycle completion pulse.
- `err_no_cup` out 1: sticky cup-timeout flag.

## Operation
- Reset: state IDLE, all counters 0, every output 0, latched selection/coin count 0.
- All outputs are registered.
- IDLE:
  - A request is `out_en | change_en`.
  - On a request: latch `drink_idx` = lowest set bit of `out` and `drink_vld` = (`out` != 0) when `out_en` is high, else `drink_vld` = 0.
  - Latch `coins` = `change` when `change_en` is high, else 0.
  - Clear `err_no_cup`.
  - Next state: CHECK if `drink_vld`, else CHANGE.
- CHECK: wait for `cup_present`.
  - If seen, go to BREW.
  - After CUP_WAIT cycles without it, set `err_no_cup` and go to CHANGE. The drink is skipped; change is still paid.
- BREW: `brew_on` = 1 for exactly BREW_CYCLES cycles, then POUR.
- POUR: `pour_on` = 1 << `drink_idx` for POUR_CYCLES cycles, then CHANGE.
  - If `cup_present` falls during POUR: `pour_on` drops the next cycle, `err_no_cup` is set, and the block goes to CHANGE.
- CHANGE: if `coins` == 0, go to DONE. Otherwise eject coins:
  - Each coin is COIN_PULSE cycles with `coin_eject` = 1, then COIN_GAP cycles with `coin_eject` = 0.
  - `coins` decrements at the end of each gap.
  - Go to DONE when it reaches 0.
- DONE: `done` = 1 for one cycle, then IDLE.
- Requests arriving while `busy` = 1 are ignored; they are not queued.
- Simultaneous `out_en` and `change_en` count as one request (the normal case).
- Multi-bit `out`: the lowest set bit wins. `pour_on` is never more than one-hot.
- Phase counter width is `$clog2` of the largest parameter + 1. The counter clears on every state entry.
- `rst` mid-sequence returns to IDLE on the next edge and drops all actuators. No coins are paid.

## Timing
- Request sampled at edge T. CHECK from T+1.
- `cup_present` already high at T+1 gives BREW at T+2, so `brew_on` is high for cycles T+2 .. T+1+BREW_CYCLES.
- POUR follows immediately, with no dead cycle between phases.
- Full drink with N coins, cup present: `done` at T+2+BREW+POUR+N·(COIN_PULSE+COIN_GAP) (+1 when N = 0 for the CHANGE pass-through).
- `busy` rises at T+1 and falls the cycle after `done`. IDLE accepts a new request in that same cycle.
- `err_no_cup` holds until the next accepted request.

## Test plan
- Reset release, idle 10 cycles: all outputs 0, `busy` = 0.
- `out_en` with `out` = 4'b0100, `change_en` with `change` = 1, cup present (defaults):
  - `brew_on` high 8 cycles.
  - `pour_on` = 4'b0100 for 4 cycles.
  - One `coin_eject` pulse, 2 cycles wide.
  - `done` 17 cycles after the strobe.
- Same request with cup absent: `err_no_cup` rises after 16 CHECK cycles, no `brew_on`/`pour_on`, the 1 coin is still ejected, then `done`.
- `change_en` only, `change` = 3: three 2-high/2-low `coin_eject` pulses, `done`, `brew_on` never asserted.
- Cup removed on the 2nd POUR cycle: `pour_on` = 0 next cycle, `err_no_cup` = 1, change paid. Also a second `out_en` while `busy` is high must be ignored.
- `rst` asserted mid-BREW: next cycle all outputs 0, IDLE. `out` = 4'b1010 afterwards selects `pour_on` = 4'b0010.

Source files
------------

// File: rtl/coffee_dispense_ctrl.sv
// Dispense sequencer: cup check, brew, one-hot pour and timed change ejection
// after a drink/change strobe from the vending front end.
module coffee_dispense_ctrl #(
    parameter int BREW_CYCLES = 8,
    parameter int POUR_CYCLES = 4,
    parameter int CUP_WAIT    = 16,
    parameter int COIN_PULSE  = 2,
    parameter int COIN_GAP    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       out_en,
    input  logic [3:0] out,
    input  logic       change_en,
    input  logic [1:0] change,
    input  logic       cup_present,
    output logic       busy,
    output logic       brew_on,
    output logic [3:0] pour_on,
    output logic       coin_eject,
    output logic       done,
    output logic       err_no_cup
);

    localparam int MAX_A = (BREW_CYCLES > POUR_CYCLES) ? BREW_CYCLES : POUR_CYCLES;
    localparam int MAX_B = (CUP_WAIT > COIN_PULSE) ? CUP_WAIT : COIN_PULSE;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_P = (MAX_C > COIN_GAP) ? MAX_C : COIN_GAP;
    localparam int CNT_W = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] CUP_LAST   = CNT_W'(CUP_WAIT - 1);
    localparam logic [CNT_W-1:0] BREW_LAST  = CNT_W'(BREW_CYCLES - 1);
    localparam logic [CNT_W-1:0] POUR_LAST  = CNT_W'(POUR_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_END  = CNT_W'(COIN_PULSE);
    localparam logic [CNT_W-1:0] COIN_LAST  = CNT_W'(COIN_PULSE + COIN_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_BREW,
        S_POUR,
        S_CHANGE,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_coins;
    logic [1:0]       w_coins_nxt;
    logic [1:0]       r_drink_idx;
    logic [1:0]       w_idx_nxt;
    logic             r_drink_vld;
    logic             w_vld_nxt;
    logic             r_err;
    logic             w_err_nxt;

    logic             r_busy;
    logic             r_brew;
    logic [3:0]       r_pour;
    logic             r_eject;
    logic             r_done;
    logic             w_busy_nxt;
    logic             w_brew_nxt;
    logic [3:0]       w_pour_nxt;
    logic             w_eject_nxt;
    logic             w_done_nxt;

    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_coins_nxt = r_coins;
        w_idx_nxt   = r_drink_idx;
        w_vld_nxt   = r_drink_vld;
        w_err_nxt   = r_err;

        case (r_state)
            S_IDLE: begin
                if (out_en || change_en) begin
                    w_idx_nxt   = lowest_set(out);
                    w_vld_nxt   = out_en && (out != 4'b0000);
                    w_coins_nxt = change_en ? change : 2'd0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = w_vld_nxt ? S_CHECK : S_CHANGE;
                end
            end
            S_CHECK: begin
                if (cup_present) begin
                    w_state_nxt = S_BREW;
                end else if (r_cnt == CUP_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_CHANGE;
                end
            end
            S_BREW: begin
                if (r_cnt == BREW_LAST) w_state_nxt = S_POUR;
            end
            S_POUR: begin
                // A lifted cup aborts the pour immediately but still pays change
                if (!cup_present) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_CHANGE;
                end else if (r_cnt == POUR_LAST) begin
                    w_state_nxt = S_CHANGE;
                end
            end
            S_CHANGE: begin
                if (r_coins == 2'd0) begin
                    w_state_nxt = S_DONE;
                end else if (r_cnt == COIN_LAST) begin
                    w_coins_nxt = r_coins - 2'd1;
                    w_cnt_nxt   = '0;
                    if (r_coins == 2'd1) w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_state_nxt != r_state || w_state_nxt == S_IDLE) w_cnt_nxt = '0;

        // Outputs are registered from the next state so they line up with it
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_brew_nxt  = (w_state_nxt == S_BREW);
        w_pour_nxt  = (w_state_nxt == S_POUR && w_vld_nxt) ? (4'b0001 << w_idx_nxt) : 4'b0000;
        w_eject_nxt = (w_state_nxt == S_CHANGE) && (w_coins_nxt != 2'd0) && (w_cnt_nxt < PULSE_END);
        w_done_nxt  = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_coins     <= 2'd0;
            r_drink_idx <= 2'd0;
            r_drink_vld <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_brew      <= 1'b0;
            r_pour      <= 4'b0000;
            r_eject     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_coins     <= w_coins_nxt;
            r_drink_idx <= w_idx_nxt;
            r_drink_vld <= w_vld_nxt;
            r_err       <= w_err_nxt;
            r_busy      <= w_busy_nxt;
            r_brew      <= w_brew_nxt;
            r_pour      <= w_pour_nxt;
            r_eject     <= w_eject_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign busy       = r_busy;
    assign brew_on    = r_brew;
    assign pour_on    = r_pour;
    assign coin_eject = r_eject;
    assign done       = r_done;
    assign err_no_cup = r_err;

endmodule

// File: tb/tb_coffee_dispense_ctrl.sv
// Bench for coffee_dispense_ctrl: a timeline model of the dispense sequence is
// compared against the outputs every cycle, plus hand-computed directed checks.
module tb_coffee_dispense_ctrl;

    localparam int BREW  = 8;
    localparam int POUR  = 4;
    localparam int CWAIT = 16;
    localparam int PULSE = 2;
    localparam int GAP   = 2;

    logic       clk;
    logic       rst;
    logic       out_en;
    logic [3:0] out;
    logic       change_en;
    logic [1:0] change;
    logic       cup_present;
    logic       busy;
    logic       brew_on;
    logic [3:0] pour_on;
    logic       coin_eject;
    logic       done;
    logic       err_no_cup;

    coffee_dispense_ctrl #(
        .BREW_CYCLES(BREW),
        .POUR_CYCLES(POUR),
        .CUP_WAIT   (CWAIT),
        .COIN_PULSE (PULSE),
        .COIN_GAP   (GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .out_en     (out_en),
        .out        (out),
        .change_en  (change_en),
        .change     (change),
        .cup_present(cup_present),
        .busy       (busy),
        .brew_on    (brew_on),
        .pour_on    (pour_on),
        .coin_eject (coin_eject),
        .done       (done),
        .err_no_cup (err_no_cup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic chk_on = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    logic       x_busy, x_brew, x_eject, x_done, x_err;
    logic [3:0] x_pour;
    logic       m_abort, m_req, m_oe, m_ce, m_cup;
    logic [3:0] m_out;
    logic [1:0] m_ch;

    task automatic step();
        @(posedge clk);
        m_abort = rst;
        m_req   = out_en | change_en;
        m_oe    = out_en;
        m_ce    = change_en;
        m_out   = out;
        m_ch    = change;
        m_cup   = cup_present;
    endtask

    task automatic model_seq();
        int   idx;
        int   n;
        logic drink;
        logic cup_ok;
        drink = m_oe && (m_out != 4'b0000);
        idx = 0;
        for (int b = 3; b >= 0; b--) if (m_out[b]) idx = b;
        n = m_ce ? int'(m_ch) : 0;
        x_err = 1'b0; x_busy = 1'b1; x_brew = 1'b0; x_pour = 4'b0000;
        x_eject = 1'b0; x_done = 1'b0;
        if (drink) begin
            cup_ok = 1'b0;
            for (int i = 0; i < CWAIT; i++) begin
                step();
                if (m_abort) return;
                if (m_cup) begin cup_ok = 1'b1; break; end
            end
            if (cup_ok) begin
                x_brew = 1'b1;
                repeat (BREW) begin step(); if (m_abort) return; end
                x_brew = 1'b0;
                x_pour[idx] = 1'b1;
                for (int i = 0; i < POUR; i++) begin
                    step();
                    if (m_abort) return;
                    if (!m_cup) begin x_err = 1'b1; break; end
                end
                x_pour = 4'b0000;
            end else begin
                x_err = 1'b1;
            end
        end
        if (n == 0) begin
            step();
            if (m_abort) return;
        end else begin
            for (int c = 0; c < n; c++) begin
                x_eject = 1'b1;
                repeat (PULSE) begin step(); if (m_abort) return; end
                x_eject = 1'b0;
                repeat (GAP) begin step(); if (m_abort) return; end
            end
        end
        x_done = 1'b1;
        step();
    endtask

    initial begin
        x_busy = 0; x_brew = 0; x_pour = 0; x_eject = 0; x_done = 0; x_err = 0;
        step();
        forever begin
            if (m_abort) begin
                x_busy = 0; x_brew = 0; x_pour = 0; x_eject = 0; x_done = 0; x_err = 0;
                step();
            end else if (m_req) begin
                model_seq();
            end else begin
                x_busy = 0; x_brew = 0; x_pour = 0; x_eject = 0; x_done = 0;
                step();
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("cyc_busy",  int'(busy),       int'(x_busy));
            check("cyc_brew",  int'(brew_on),    int'(x_brew));
            check("cyc_pour",  int'(pour_on),    int'(x_pour));
            check("cyc_eject", int'(coin_eject), int'(x_eject));
            check("cyc_done",  int'(done),       int'(x_done));
            check("cyc_err",   int'(err_no_cup), int'(x_err));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run_req(input logic oe, input logic [3:0] o, input logic ce,
                           input logic [1:0] ch, input logic cup0,
                           input int drop_k, input int extra_k, input int rst_k,
                           output int done_k, output int n_brew, output int n_pour,
                           output logic [3:0] pour_seen, output int n_eject,
                           output int err_k);
        done_k = -1; n_brew = 0; n_pour = 0; pour_seen = 4'b0000; n_eject = 0; err_k = -1;
        @(negedge clk);
        cup_present = cup0; out_en = oe; out = o; change_en = ce; change = ch;
        @(negedge clk);
        out_en = 1'b0; change_en = 1'b0;
        for (int k = 0; k < 200; k++) begin
            n_brew += int'(brew_on);
            if (pour_on != 4'b0000) n_pour++;
            pour_seen |= pour_on;
            n_eject += int'(coin_eject);
            if (err_no_cup && err_k < 0) err_k = k;
            if (done) begin done_k = k; break; end
            if (rst_k >= 0 && k == rst_k + 1) begin
                check("rst_busy",  int'(busy),       0);
                check("rst_brew",  int'(brew_on),    0);
                check("rst_pour",  int'(pour_on),    0);
                check("rst_eject", int'(coin_eject), 0);
                rst = 1'b0;
                done_k = k;
                break;
            end
            if (k == rst_k) rst = 1'b1;
            if (k == drop_k) cup_present = 1'b0;
            if (k == extra_k) begin out_en = 1'b1; out = 4'b0001; end
            else if (k == extra_k + 1) out_en = 1'b0;
            @(negedge clk);
        end
        if (done_k < 0) check("seq_timeout", 0, 1);
        else if (rst_k < 0) begin
            @(negedge clk);
            check("busy_after_done", int'(busy), 0);
        end
    endtask

    int dk, nb, np, ne, ek;
    logic [3:0] ps;

    initial begin
        rst = 1'b1; out_en = 0; out = 0; change_en = 0; change = 0; cup_present = 0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("idle_outs", int'({busy, brew_on, pour_on, coin_eject, done, err_no_cup}), 0);
            @(negedge clk);
        end

        // full drink, 1 coin, cup present
        run_req(1, 4'b0100, 1, 2'd1, 1, -1, -1, -1, dk, nb, np, ps, ne, ek);
        check("t1_done_k", dk, 17);
        check("t1_brew",   nb, 8);
        check("t1_pour_n", np, 4);
        check("t1_pour",   int'(ps), 4);
        check("t1_eject",  ne, 2);
        check("t1_err",    ek, -1);

        // cup absent: timeout, change still paid
        run_req(1, 4'b0100, 1, 2'd1, 0, -1, -1, -1, dk, nb, np, ps, ne, ek);
        check("t2_err_k",  ek, 16);
        check("t2_done_k", dk, 20);
        check("t2_brew",   nb, 0);
        check("t2_pour_n", np, 0);
        check("t2_eject",  ne, 2);
        check("t2_err_sticky", int'(err_no_cup), 1);

        // change only, 3 coins
        run_req(0, 4'b0000, 1, 2'd3, 1, -1, -1, -1, dk, nb, np, ps, ne, ek);
        check("t3_done_k", dk, 12);
        check("t3_eject",  ne, 6);
        check("t3_brew",   nb, 0);
        check("t3_err_clr", int'(err_no_cup), 0);

        // cup lifted on 2nd pour cycle, extra request while busy
        run_req(1, 4'b0100, 1, 2'd1, 1, 10, 3, -1, dk, nb, np, ps, ne, ek);
        check("t4_pour_n", np, 2);
        check("t4_err_k",  ek, 11);
        check("t4_eject",  ne, 2);
        check("t4_done_k", dk, 15);
        check("t4_brew",   nb, 8);

        // reset mid-brew, then multi-bit selection
        run_req(1, 4'b0100, 1, 2'd2, 1, -1, -1, 4, dk, nb, np, ps, ne, ek);
        check("t5_rst_k",  dk, 5);
        check("t5_eject",  ne, 0);
        run_req(1, 4'b1010, 0, 2'd0, 1, -1, -1, -1, dk, nb, np, ps, ne, ek);
        check("t6_pour",   int'(ps), 2);
        check("t6_pour_n", np, 4);
        check("t6_done_k", dk, 14);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
